// File: rtl/txrx_pkg.sv
// Shared definitions for the attenuated-channel link (transmitter and receiver).
// Holds the attenuation code set, the sample widths, the transmitter state
// encoding and the code-to-shift decode that both ends must agree on.
package txrx_pkg;

   // Legal attenuation codes
   localparam logic [4:0] ATTEN_2  = 5'd2;
   localparam logic [4:0] ATTEN_4  = 5'd4;
   localparam logic [4:0] ATTEN_8  = 5'd8;
   localparam logic [4:0] ATTEN_16 = 5'd16;

   // Input sample width and channel sample width (input width plus max shift)
   localparam int SIG_IN_W = 18;
   localparam int SIG_CH_W = 21;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_FLUSH = 2'd1,
      TX_DATA  = 2'd2
   } tx_state_t;

   typedef struct packed {
      logic       legal;
      logic [1:0] shift;
   } atten_info_t;

   // Code 2/4/8/16 maps to a left shift of 0/1/2/3 (i.e. log2(code) - 1).
   // Any other code is flagged illegal and reports a shift of 0.
   function automatic atten_info_t atten_decode(input logic [4:0] code);
      atten_info_t info;
      info.legal = 1'b1;
      info.shift = 2'd0;
      case (code)
         ATTEN_2:  info.shift = 2'd0;
         ATTEN_4:  info.shift = 2'd1;
         ATTEN_8:  info.shift = 2'd2;
         ATTEN_16: info.shift = 2'd3;
         default:  info.legal = 1'b0;
      endcase
      return info;
   endfunction

endpackage

// File: rtl/tx_lfsr_noise.sv
// Noise source for the channel transmitter: 16-bit Fibonacci LFSR
// (taps 16,14,13,11) whose low nibble is sign-extended to channel width.
// Only instantiated when CHANNEL_TX_NOISE_EN is defined.
module tx_lfsr_noise
   import txrx_pkg::*;
(
   input  logic                CLK,
   input  logic                RESET,
   input  logic                i_advance,
   output logic [SIG_CH_W-1:0] o_noise
);

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   logic [15:0] r_lfsr;
   logic        w_feedback;

   assign w_feedback = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

   // Step the LFSR once for every sample leaving the scale stage
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_lfsr <= LFSR_SEED;
      end else if (i_advance) begin
         r_lfsr <= {r_lfsr[14:0], w_feedback};
      end
   end

   assign o_noise = {{(SIG_CH_W-4){r_lfsr[3]}}, r_lfsr[3:0]};

endmodule

// File: rtl/channel_transmitter.sv
// Transmit end of the attenuated-channel link.
// Each frame: FLUSH_LEN zero samples, then FRAME_LEN data slots. Every sample
// is pre-scaled by ATTEN/2 (left shift 0..3) so the receiver's fixed bit
// slice recovers it. Two-stage pipeline: capture, then scale.
// Optional build macro: CHANNEL_TX_NOISE_EN adds saturated LFSR noise to
// data samples (flush samples stay exactly zero).
module channel_transmitter
   import txrx_pkg::*;
#(
   parameter int FLUSH_LEN = 32,
   parameter int FRAME_LEN = 256,
   parameter int CNT_W     = 9
)(
   input  logic                CLK,
   input  logic                RESET,
   input  logic                SAMPLE_EN,
   input  logic                START,
   input  logic [4:0]          ATTEN_SEL,
   input  logic [SIG_IN_W-1:0] DATA_IN,
   input  logic                DATA_VALID,
   output logic                DATA_READY,
   output logic [SIG_CH_W-1:0] SIGNAL_OUT,
   output logic [4:0]          ATTEN_OUT,
   output logic                OUT_VALID,
   output logic                BUSY,
   output logic                ATTEN_ERR,
   output logic                UNDERRUN
);

   localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_LEN - 1);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);

   tx_state_t           r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [4:0]          r_atten_q;
   logic [1:0]          r_shift;
   logic                r_atten_err;
   logic                r_underrun;

   logic                r_s1_valid;
   logic [SIG_IN_W-1:0] r_s1_data;
   logic                r_s2_valid;
   logic [SIG_CH_W-1:0] r_signal;
   logic [4:0]          r_atten_out;

   atten_info_t         w_info;
   logic                w_slot;
   logic                w_xfer;
   logic [SIG_CH_W-1:0] w_scaled;
   logic [SIG_CH_W-1:0] w_final;

   assign w_info     = atten_decode(ATTEN_SEL);
   assign DATA_READY = (r_state == TX_DATA) && SAMPLE_EN;
   assign w_xfer     = DATA_READY && DATA_VALID;
   assign w_slot     = SAMPLE_EN && (r_state != TX_IDLE);

   // Frame sequencing: IDLE -> FLUSH -> DATA -> IDLE, plus error/underrun flags
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state     <= TX_IDLE;
         r_cnt       <= '0;
         r_atten_q   <= '0;
         r_shift     <= '0;
         r_atten_err <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_atten_err <= 1'b0;
         case (r_state)
            TX_IDLE: begin
               if (START) begin
                  r_atten_q <= ATTEN_SEL;
                  r_shift   <= w_info.shift;
                  if (w_info.legal) begin
                     r_state    <= TX_FLUSH;
                     r_cnt      <= '0;
                     r_underrun <= 1'b0;
                  end else begin
                     r_atten_err <= 1'b1;
                  end
               end
            end
            TX_FLUSH: begin
               if (SAMPLE_EN) begin
                  if (r_cnt == FLUSH_LAST) begin
                     r_state <= TX_DATA;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            TX_DATA: begin
               if (SAMPLE_EN) begin
                  if (!DATA_VALID) begin
                     r_underrun <= 1'b1;
                  end
                  if (r_cnt == FRAME_LAST) begin
                     r_state <= TX_IDLE;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            default: r_state <= TX_IDLE;
         endcase
      end
   end

`ifdef CHANNEL_TX_NOISE_EN
   logic                r_s1_is_data;
   logic [SIG_CH_W-1:0] w_noise;
   logic [SIG_CH_W:0]   w_sum;

   tx_lfsr_noise u_noise (
      .CLK       (CLK),
      .RESET     (RESET),
      .i_advance (r_s1_valid),
      .o_noise   (w_noise)
   );

   // Remember whether the captured sample carries real data (noise target)
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_s1_is_data <= 1'b0;
      end else if (w_slot) begin
         r_s1_is_data <= w_xfer;
      end
   end

   // One extra bit of headroom, then clamp back into the signed channel range
   assign w_sum = {w_scaled[SIG_CH_W-1], w_scaled}
                + (r_s1_is_data ? {w_noise[SIG_CH_W-1], w_noise} : '0);
   assign w_final = (w_sum[SIG_CH_W] != w_sum[SIG_CH_W-1])
                  ? (w_sum[SIG_CH_W] ? {1'b1, {(SIG_CH_W-1){1'b0}}}
                                     : {1'b0, {(SIG_CH_W-1){1'b1}}})
                  : w_sum[SIG_CH_W-1:0];
`else
   assign w_final = w_scaled;
`endif

   // Capture stage: flush slots and underrun slots enter as zero
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
      end else begin
         r_s1_valid <= w_slot;
         if (w_slot) begin
            r_s1_data <= w_xfer ? DATA_IN : '0;
         end
      end
   end

   assign w_scaled = {{(SIG_CH_W-SIG_IN_W){r_s1_data[SIG_IN_W-1]}}, r_s1_data} << r_shift;

   // Scale stage: register the shifted sample and its code; return to zero when idle
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_s2_valid  <= 1'b0;
         r_signal    <= '0;
         r_atten_out <= '0;
      end else begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_signal    <= w_final;
            r_atten_out <= r_atten_q;
         end else if ((r_state == TX_IDLE) && !r_s2_valid) begin
            r_signal <= '0;
         end
      end
   end

   assign SIGNAL_OUT = r_signal;
   assign ATTEN_OUT  = r_atten_out;
   assign OUT_VALID  = r_s2_valid;
   assign ATTEN_ERR  = r_atten_err;
   assign UNDERRUN   = r_underrun;
   assign BUSY       = (r_state != TX_IDLE) || r_s1_valid || r_s2_valid;

endmodule

// File: tb/tb_channel_transmitter.sv
// Self-checking bench for channel_transmitter: randomized frames, expected
// samples queued at stimulus time, checked by an independent output monitor.
`timescale 1ns/1ps
module tb_channel_transmitter;

   localparam int FLUSH_LEN = 32;
   localparam int FRAME_LEN = 256;
   localparam int CNT_W     = 9;

   logic        CLK        = 1'b0;
   logic        RESET      = 1'b1;
   logic        SAMPLE_EN  = 1'b0;
   logic        START      = 1'b0;
   logic [4:0]  ATTEN_SEL  = 5'd0;
   logic [17:0] DATA_IN    = 18'd0;
   logic        DATA_VALID = 1'b0;
   logic        DATA_READY;
   logic [20:0] SIGNAL_OUT;
   logic [4:0]  ATTEN_OUT;
   logic        OUT_VALID;
   logic        BUSY;
   logic        ATTEN_ERR;
   logic        UNDERRUN;

   channel_transmitter #(
      .FLUSH_LEN (FLUSH_LEN),
      .FRAME_LEN (FRAME_LEN),
      .CNT_W     (CNT_W)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .SAMPLE_EN  (SAMPLE_EN),
      .START      (START),
      .ATTEN_SEL  (ATTEN_SEL),
      .DATA_IN    (DATA_IN),
      .DATA_VALID (DATA_VALID),
      .DATA_READY (DATA_READY),
      .SIGNAL_OUT (SIGNAL_OUT),
      .ATTEN_OUT  (ATTEN_OUT),
      .OUT_VALID  (OUT_VALID),
      .BUSY       (BUSY),
      .ATTEN_ERR  (ATTEN_ERR),
      .UNDERRUN   (UNDERRUN)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [20:0] sig;
      logic [4:0]  atten;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   exp_underrun = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: the channel sample is the input value times ATTEN/2, in 21-bit two's complement
   function automatic logic [20:0] model(input logic [17:0] d, input logic [4:0] code);
      logic signed [31:0] v;
      int m;
      m = int'(code) / 2;
      v = $signed(d);
      v = v * m;
      return v[20:0];
   endfunction

   task automatic push_exp(input logic [20:0] sig, input logic [4:0] atten);
      exp_t t;
      t.sig   = sig;
      t.atten = atten;
      sb.push_back(t);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) tick();
   endtask

   // Monitor: every OUT_VALID consumes exactly one expected sample
   always @(negedge CLK) begin
      if (OUT_VALID) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_out: got SIGNAL_OUT=%h ATTEN_OUT=%0d with no sample pending", SIGNAL_OUT, ATTEN_OUT);
         end else begin
            mon_e = sb.pop_front();
            check("sample", {6'd0, ATTEN_OUT, SIGNAL_OUT}, {6'd0, mon_e.atten, mon_e.sig});
            $display("out  sig=%h atten=%0d exp_sig=%h", SIGNAL_OUT, ATTEN_OUT, mon_e.sig);
         end
      end
   end

   task automatic run_frame(input logic [4:0] code, input int miss_slot, input int abort_slot,
                            input logic [17:0] d0);
      logic [17:0] d;
      bit          v;
      START      = 1'b1;
      ATTEN_SEL  = code;
      SAMPLE_EN  = 1'b1;
      DATA_VALID = 1'b1;
      #1 check("ready_at_start", DATA_READY, 0);
      tick();
      START     = 1'b0;
      SAMPLE_EN = 1'b0;
      exp_underrun = 1'b0;
      check("underrun_cleared", UNDERRUN, 0);
      check("busy_in_frame", BUSY, 1);
      $display("start code=%0d", code);

      for (int i = 0; i < FLUSH_LEN; i++) begin
         gap();
         ATTEN_SEL  = 5'($urandom);
         SAMPLE_EN  = 1'b1;
         DATA_VALID = 1'($urandom);
         DATA_IN    = 18'($urandom);
         #1 check("ready_flush", DATA_READY, 0);
         push_exp(21'd0, code);
         tick();
         SAMPLE_EN = 1'b0;
      end

      for (int i = 0; i < FRAME_LEN; i++) begin
         gap();
         if (i == abort_slot) begin
            RESET      = 1'b1;
            SAMPLE_EN  = 1'b1;
            DATA_VALID = 1'b1;
            tick();
            sb.delete();
            exp_underrun = 1'b0;
            check("rst_signal", SIGNAL_OUT, 0);
            check("rst_atten", ATTEN_OUT, 0);
            check("rst_valid", OUT_VALID, 0);
            check("rst_busy", BUSY, 0);
            check("rst_underrun", UNDERRUN, 0);
            check("rst_err", ATTEN_ERR, 0);
            check("rst_ready", DATA_READY, 0);
            $display("reset at data slot %0d", i);
            RESET     = 1'b0;
            SAMPLE_EN = 1'b0;
            tick();
            return;
         end
         d = (i == 0) ? d0 : 18'($urandom);
         v = (i != miss_slot);
         SAMPLE_EN  = 1'b1;
         DATA_VALID = v;
         DATA_IN    = d;
         ATTEN_SEL  = 5'($urandom);
         START      = (i == 5);
         #1 check("ready_data", DATA_READY, 1);
         push_exp(v ? model(d, code) : 21'd0, code);
         if (!v) exp_underrun = 1'b1;
         tick();
         SAMPLE_EN = 1'b0;
         START     = 1'b0;
         check("underrun_flag", UNDERRUN, exp_underrun);
         if (i == 5) check("start_ignored_err", ATTEN_ERR, 0);
      end

      SAMPLE_EN = 1'b1;
      #1 check("ready_after_frame", DATA_READY, 0);
      tick();
      SAMPLE_EN = 1'b0;
      repeat (4) tick();
      check("busy_after_frame", BUSY, 0);
      check("sb_drained", sb.size(), 0);
      check("underrun_end", UNDERRUN, exp_underrun);
   endtask

   task automatic illegal_start(input logic [4:0] code);
      START     = 1'b1;
      ATTEN_SEL = code;
      SAMPLE_EN = 1'b1;
      tick();
      START     = 1'b0;
      SAMPLE_EN = 1'b0;
      check("atten_err_pulse", ATTEN_ERR, 1);
      check("busy_after_illegal", BUSY, 0);
      check("underrun_kept", UNDERRUN, exp_underrun);
      tick();
      check("atten_err_single", ATTEN_ERR, 0);
      SAMPLE_EN = 1'b1;
      #1 check("ready_after_illegal", DATA_READY, 0);
      tick();
      SAMPLE_EN = 1'b0;
      repeat (3) tick();
      check("busy_idle", BUSY, 0);
      $display("illegal start code=%0d", code);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET     = 1'b1;
      SAMPLE_EN = 1'b1;
      repeat (3) tick();
      check("reset_signal", SIGNAL_OUT, 0);
      check("reset_atten", ATTEN_OUT, 0);
      check("reset_valid", OUT_VALID, 0);
      check("reset_busy", BUSY, 0);
      check("reset_underrun", UNDERRUN, 0);
      check("reset_err", ATTEN_ERR, 0);
      check("reset_ready", DATA_READY, 0);
      RESET     = 1'b0;
      SAMPLE_EN = 1'b0;
      tick();

      run_frame(5'd8,  -1, -1, 18'h00100);
      illegal_start(5'd5);
      run_frame(5'd16,  3, -1, 18'h3FFFF);
      illegal_start(5'd0);
      run_frame(5'd2,  -1, -1, 18'h1FFFF);
      illegal_start(5'd12);
      run_frame(5'd8,   3, 10, 18'($urandom));
      run_frame(5'd4,  -1, -1, 18'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/channel_transmitter.md
Name: channel_transmitter

Overview:
- Transmit end of the attenuated-channel link; produces the stream that the downstream receiver undoes.
- Accepts 18-bit signed samples over a ready/valid handshake, paced by a sample strobe.
- Pre-scales each sample by ATTEN/2, giving a shift of 0..3, so the receiver's fixed bit-slice recovers it. Outputs a 21-bit signal plus the attenuation code.
- Each frame is preceded by a zero flush so the receiver's 32-tap averaging filter starts clean.

Parameters:
- FLUSH_LEN, 32, zero samples emitted before data; equals receiver filter depth.
- FRAME_LEN, 256, sample slots per data frame; must be >= 1.
- CNT_W, 9, width of the slot counter; must hold max(FLUSH_LEN, FRAME_LEN).

Ports:
- CLK  in  1  clock
- RESET  in  1  reset
- SAMPLE_EN  in  1  one-cycle strobe per sample period
- START  in  1  pulse; begins a frame
- ATTEN_SEL  in  5  attenuation code; legal values 2/4/8/16
- DATA_IN  in  18  signed sample
- DATA_VALID  in  1  DATA_IN valid
- DATA_READY  out  1  transfer accepted this cycle
- SIGNAL_OUT  out  21  scaled channel sample
- ATTEN_OUT  out  5  attenuation code sent with the signal
- OUT_VALID  out  1  SIGNAL_OUT is a new sample
- BUSY  out  1  frame or pipeline active
- ATTEN_ERR  out  1  one-cycle pulse: START had an illegal code
- UNDERRUN  out  1  sticky: a DATA slot had no valid input

Behaviour:
- Reset is synchronous, active-high RESET on the CLK rising edge. It forces state IDLE and zeroes counters and the pipeline. All outputs are 0, including ATTEN_OUT and UNDERRUN.
- Reset mid-frame aborts immediately. There is no partial-sample completion.
- States: IDLE, FLUSH, DATA.
- IDLE:
  - SIGNAL_OUT holds 0; ATTEN_OUT holds the last latched code.
  - On START: latch ATTEN_SEL into atten_q and k = log2(ATTEN_SEL) - 1.
  - If the code is legal: go to FLUSH, counter = 0, clear UNDERRUN.
  - If the code is illegal: pulse ATTEN_ERR next cycle and stay in IDLE.
  - SAMPLE_EN in the same cycle as START is ignored.
- FLUSH:
  - Each SAMPLE_EN emits one zero sample.
  - After FLUSH_LEN strobes go to DATA with counter = 0.
- DATA:
  - DATA_READY = SAMPLE_EN while in DATA, driven combinationally. A transfer occurs when DATA_READY and DATA_VALID are both high.
  - A SAMPLE_EN without DATA_VALID emits 0 and sets UNDERRUN.
  - After FRAME_LEN slots (transfers plus underruns) go to IDLE.
- START outside IDLE is ignored.
- ATTEN_SEL changes mid-frame are ignored; atten_q is stable for the whole frame.
- Pipeline: two stages (capture, scale).
  - A slot strobed at cycle N gives SIGNAL_OUT and OUT_VALID at cycle N+2.
  - OUT_VALID is high for exactly one cycle; SIGNAL_OUT holds its value until the next sample.
- Arithmetic:
  - SIGNAL_OUT = sign-extend(DATA_IN, 21) <<< k.
  - k = 0/1/2/3 for codes 2/4/8/16.
  - No overflow is possible because 18 + 3 = 21.
- ATTEN_OUT = atten_q, registered and aligned with SIGNAL_OUT.
- BUSY = (state != IDLE) OR either pipeline stage valid. It falls two cycles after the last DATA slot.

Optional Feature:
- Macro: CHANNEL_TX_NOISE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per emitted sample.
  - Its low 4 bits, sign-extended, are added to SIGNAL_OUT during DATA samples only. Flush samples stay exactly 0.
  - The sum saturates to the 21-bit signed range.
  - Pipeline latency is unchanged.
- Undefined: no LFSR logic exists and the output is noise-free.

Decomposition:
- Package txrx_pkg holds:
  - ATTEN_2/4/8/16 code constants
  - SIG_IN_W = 18 and SIG_CH_W = 21
  - the tx state enum
  - a function mapping code to shift with a legality flag; the receiver shares this mapping.
- One sub-module, tx_lfsr_noise: the LFSR plus sign-extend, instantiated only under CHANNEL_TX_NOISE_EN.

Test Plan:
- Reset, then START with ATTEN_SEL=8 and 32 strobes → 32 zero samples with OUT_VALID; ATTEN_OUT = 8; DATA_READY = 0 throughout.
- DATA phase, ATTEN_SEL=8, DATA_IN = 18'h00100 (256) → SIGNAL_OUT = 21'h000400 at N+2; bits [19:2] equal 256.
- ATTEN_SEL=16, DATA_IN = 18'h3FFFF (-1) → SIGNAL_OUT = 21'h1FFFF8. ATTEN_SEL=2, DATA_IN = 18'h1FFFF → SIGNAL_OUT = 21'h01FFFF.
- START with ATTEN_SEL=5 → ATTEN_ERR pulses one cycle; state stays IDLE; BUSY = 0; no OUT_VALID.
- DATA_VALID low on slot 3 of the frame → SIGNAL_OUT = 0 for that slot; UNDERRUN = 1 and stays set until the next legal START; frame still ends after FRAME_LEN slots.
- RESET asserted at DATA slot 10 → next cycle all outputs 0, state IDLE; a new START with ATTEN_SEL=4 restarts FLUSH from count 0.
